// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets,
// synchroniser depth and the byte-lane expansion helper.
package irq_ctrl_pkg;

  localparam logic [2:0] REG_PENDING  = 3'd0;
  localparam logic [2:0] REG_ENABLE   = 3'd1;
  localparam logic [2:0] REG_MODE     = 3'd2;
  localparam logic [2:0] REG_POLARITY = 3'd3;
  localparam logic [2:0] REG_RAW      = 3'd4;
  localparam logic [2:0] REG_SWSET    = 3'd5;

  localparam int SYNC_STAGES = 2;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    lane_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/irq_ctrl_src.sv
// One interrupt source: synchroniser, polarity, edge/level detect and
// the pending bit with clear/software-set inputs.
module irq_ctrl_src
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic polarity,
  input  logic mode,
  input  logic clr,
  input  logic swset,
  output logic raw,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_d_p1;
  logic                   set;

  // Synchroniser chain for the asynchronous source.
  always_ff @(posedge clk) begin
    if (reset) sync_p0 <= '0;
    else       sync_p0 <= {sync_p0[SYNC_STAGES-2:0], src};
  end

  // ---- stage boundary: synchronised, polarity-adjusted level ----
  assign raw = sync_p0[SYNC_STAGES-1] ^ polarity;

  // Previous value of the adjusted level, for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) s_d_p1 <= 1'b0;
    else       s_d_p1 <= raw;
  end

  // Edge mode pulses once per asserting edge; level mode follows the level.
  always_comb begin
    set = raw;
    if (mode) set = raw & ~s_d_p1;
  end

  // ---- stage boundary: pending latch; a set always wins over a clear ----
  always_ff @(posedge clk) begin
    if (reset) pending <= 1'b0;
    else       pending <= (pending & ~clr) | set | swset;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding the picorv32 irq vector.
// Single-wait-state bus slave; one ready pulse per access.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC  = 8,
  parameter int IRQ_BASE = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  output logic               ready,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] src,
  output logic [31:0]        irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]         state;
  logic [NUM_SRC-1:0] enable_r;
  logic [NUM_SRC-1:0] mode_r;
  logic [NUM_SRC-1:0] polarity_r;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] raw;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] swset;
  logic [NUM_SRC-1:0] irq_p1;
  logic [NUM_SRC-1:0] wmask;
  logic [NUM_SRC-1:0] wbits;
  logic [31:0]        wmask_full;
  logic [31:0]        rd_val;
  logic [2:0]         reg_sel;
  logic               access;
  logic               wr;
  logic               unused_bits;

  function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
    zext = {{(32-NUM_SRC){1'b0}}, v};
  endfunction

  // An access is taken only from IDLE; the ACK cycle never re-acknowledges.
  assign access      = (state == ST_IDLE) && valid && !reset;
  assign wr          = access && (wstrb != 4'b0000);
  assign reg_sel     = addr[4:2];
  assign wmask_full  = lane_mask(wstrb);
  assign wmask       = wmask_full[NUM_SRC-1:0];
  assign wbits       = wdata[NUM_SRC-1:0] & wmask;
  assign ready       = (state == ST_ACK);
  assign unused_bits = ^{addr[31:5], addr[1:0], wdata[31:NUM_SRC], wmask_full[31:NUM_SRC]};

  // One-cycle clear/set strobes to the pending bits, aligned to the ack edge.
  always_comb begin
    clr   = '0;
    swset = '0;
    if (wr && reg_sel == REG_PENDING) clr   = wbits;
    if (wr && reg_sel == REG_SWSET)   swset = wbits;
  end

  // Read multiplexer; unmapped offsets and SWSET read as zero.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_PENDING:  rd_val = zext(pending);
      REG_ENABLE:   rd_val = zext(enable_r);
      REG_MODE:     rd_val = zext(mode_r);
      REG_POLARITY: rd_val = zext(polarity_r);
      REG_RAW:      rd_val = zext(raw);
      default:      rd_val = '0;
    endcase
  end

  // Bus handshake state and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      rdata <= '0;
    end else if (access) begin
      state <= ST_ACK;
      rdata <= rd_val;
    end else begin
      state <= ST_IDLE;
      rdata <= '0;
    end
  end

  // Configuration registers with per-byte-lane writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r   <= '0;
      mode_r     <= '0;
      polarity_r <= '0;
    end else if (wr) begin
      case (reg_sel)
        REG_ENABLE:   enable_r   <= (enable_r & ~wmask) | wbits;
        REG_MODE:     mode_r     <= (mode_r & ~wmask) | wbits;
        REG_POLARITY: polarity_r <= (polarity_r & ~wmask) | wbits;
        default:      ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_ctrl_src u_src (
      .clk      (clk),
      .reset    (reset),
      .src      (src[i]),
      .polarity (polarity_r[i]),
      .mode     (mode_r[i]),
      .clr      (clr[i]),
      .swset    (swset[i]),
      .raw      (raw[i]),
      .pending  (pending[i])
    );
  end

  // ---- stage boundary: registered irq output ----
  always_ff @(posedge clk) begin
    if (reset) irq_p1 <= '0;
    else       irq_p1 <= pending & enable_r;
  end

  // Place the masked pending bits at IRQ_BASE; all other bits stay zero.
  always_comb begin
    irq = '0;
    irq[IRQ_BASE +: NUM_SRC] = irq_p1;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: register table, timing corner sequences and a
// randomized transaction-level comparison against a behavioural model.
module tb_irq_ctrl;

  localparam logic [2:0] O_PEND = 3'd0, O_EN = 3'd1, O_MODE = 3'd2,
                         O_POL = 3'd3, O_RAW = 3'd4, O_SWSET = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  wstrb = 4'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  src = '0;
  logic [31:0] irq;

  int checks = 0;
  int failures = 0;

  irq_ctrl #(.NUM_SRC(8), .IRQ_BASE(5)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .src(src), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [3:0]  strb;
    logic [2:0]  off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic is_rd, input logic [3:0] strb, input logic [2:0] off,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic [31:0] exp_irq);
    vec_t v;
    v.is_rd = is_rd; v.strb = strb; v.off = off; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    tbl.push_back(v);
  endtask

  // One bus access: valid is held through the ACK cycle to prove no re-ack.
  task automatic bus(input logic [3:0] strb, input logic [2:0] off,
                     input logic [31:0] d, output logic [31:0] rd);
    int n;
    @(negedge clk);
    valid = 1'b1; wstrb = strb; addr = {27'b0, off, 2'b00}; wdata = d;
    n = 0;
    rd = '0;
    while (!ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("bus_timeout", 32'(ready), 32'd1);
    end else begin
      rd = rdata;
      chk("bus_latency", 32'(n), 32'd1);
      @(negedge clk);
      chk("ready_single_pulse", 32'(ready), 32'd0);
    end
    valid = 1'b0; wstrb = 4'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    bus(4'b1111, off, d, dummy);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus(4'b0000, off, 32'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; valid = 1'b0; wstrb = 4'b0; src = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_irq", irq, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Behavioural model state for the randomized phase.
  logic [7:0] m_src, m_en, m_mode, m_pol, m_pend;

  initial begin
    logic [31:0] r;
    logic [7:0]  s_old, s_new, d;
    int          op;

    // ---- reset and read all offsets ----
    do_reset();
    for (int o = 0; o < 8; o++) begin
      bus(4'b0000, 3'(o), 32'h0, r);
      chk($sformatf("reset_read_off%0d", o), r, 32'd0);
    end
    chk("reset_irq_after_reads", irq, 32'd0);

    // ---- register table (src held at 0) ----
    add(0, 4'hF, O_EN,    32'hA5, 0,     32'h0);
    add(1, 4'h0, O_EN,    0,      32'hA5, 32'h0);
    add(0, 4'h2, O_EN,    32'hFF, 0,     32'h0);
    add(1, 4'h0, O_EN,    0,      32'hA5, 32'h0);
    add(0, 4'h1, O_MODE,  32'hFF, 0,     32'h0);
    add(1, 4'h0, O_MODE,  0,      32'hFF, 32'h0);
    add(1, 4'h0, 3'd6,    0,      32'h0, 32'h0);
    add(0, 4'hF, 3'd7,    32'hFF, 0,     32'h0);
    add(1, 4'h0, 3'd7,    0,      32'h0, 32'h0);
    add(1, 4'h0, O_SWSET, 0,      32'h0, 32'h0);
    add(0, 4'h1, O_SWSET, 32'h80, 0,     32'h1000);
    add(1, 4'h0, O_PEND,  0,      32'h80, 32'h1000);
    add(0, 4'h2, O_PEND,  32'h80, 0,     32'h1000);
    add(1, 4'h0, O_PEND,  0,      32'h80, 32'h1000);
    add(0, 4'hF, O_PEND,  32'hFF, 0,     32'h0);
    add(1, 4'h0, O_PEND,  0,      32'h0, 32'h0);
    add(0, 4'h1, O_POL,   32'h0F, 0,     32'hA0);
    add(1, 4'h0, O_RAW,   0,      32'h0F, 32'hA0);
    add(1, 4'h0, O_PEND,  0,      32'h0F, 32'hA0);
    add(0, 4'hF, O_POL,   32'h00, 0,     32'hA0);
    add(1, 4'h0, O_RAW,   0,      32'h0, 32'hA0);
    add(0, 4'hF, O_PEND,  32'hFF, 0,     32'h0);
    add(1, 4'h0, O_PEND,  0,      32'h0, 32'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      bus(tbl[i].strb, tbl[i].off, tbl[i].wd, r);
      if (tbl[i].is_rd) chk($sformatf("tbl%0d_rdata", i), r, tbl[i].exp_rd);
      repeat (3) @(negedge clk);
      chk($sformatf("tbl%0d_irq", i), irq, tbl[i].exp_irq);
    end

    // ---- edge source latency and clear ----
    do_reset();
    wr(O_EN, 32'h01);
    wr(O_MODE, 32'h01);
    repeat (2) @(negedge clk);
    src[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("edge_irq_before_T4", 32'(irq[5]), 32'd0);
    @(negedge clk);
    chk("edge_irq_at_T4", 32'(irq[5]), 32'd1);
    rd_chk("edge_pending", O_PEND, 32'h01);
    wr(O_PEND, 32'h01);
    @(negedge clk);
    chk("edge_irq_after_w1c", 32'(irq[5]), 32'd0);
    repeat (4) @(negedge clk);
    rd_chk("edge_no_repend", O_PEND, 32'h00);
    chk("edge_irq_stays_low", 32'(irq[5]), 32'd0);

    // ---- level source re-pends while active ----
    do_reset();
    wr(O_EN, 32'h02);
    src[1] = 1'b1;
    repeat (5) @(negedge clk);
    wr(O_PEND, 32'h02);
    rd_chk("level_repend", O_PEND, 32'h02);
    chk("level_irq_held", 32'(irq[6]), 32'd1);
    src[1] = 1'b0;
    repeat (4) @(negedge clk);
    wr(O_PEND, 32'h02);
    rd_chk("level_cleared", O_PEND, 32'h00);
    repeat (2) @(negedge clk);
    chk("level_irq_low", 32'(irq[6]), 32'd0);

    // ---- active-low / falling edge ----
    do_reset();
    src[2] = 1'b1;
    repeat (4) @(negedge clk);
    wr(O_POL, 32'h04);
    wr(O_MODE, 32'h04);
    wr(O_PEND, 32'h04);
    rd_chk("pol_pending_cleared", O_PEND, 32'h00);
    wr(O_EN, 32'h04);
    @(negedge clk);
    src[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pol_irq_before_T4", 32'(irq[7]), 32'd0);
    @(negedge clk);
    chk("pol_irq_at_T4", 32'(irq[7]), 32'd1);
    rd_chk("pol_raw", O_RAW, 32'h04);

    // ---- edge set coincident with W1C of the same bit ----
    do_reset();
    wr(O_MODE, 32'h08);
    repeat (3) @(negedge clk);
    src[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b1; wstrb = 4'hF; addr = {27'b0, O_PEND, 2'b00}; wdata = 32'h08;
    @(negedge clk);
    chk("coincident_ack", 32'(ready), 32'd1);
    @(negedge clk);
    valid = 1'b0; wstrb = 4'b0;
    rd_chk("coincident_set_wins", O_PEND, 32'h08);

    // ---- reset in the cycle a write would be acked ----
    do_reset();
    @(negedge clk);
    valid = 1'b1; wstrb = 4'hF; addr = {27'b0, O_EN, 2'b00}; wdata = 32'hFF; reset = 1'b1;
    @(negedge clk);
    chk("rst_ack_ready", 32'(ready), 32'd0);
    valid = 1'b0; wstrb = 4'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_ack_no_late_ready", 32'(ready), 32'd0);
    rd_chk("rst_ack_enable", O_EN, 32'h00);

    // ---- randomized transactions against the model ----
    do_reset();
    m_src = '0; m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0;
    for (int step = 0; step < 150; step++) begin
      op = $urandom_range(0, 5);
      d = 8'($urandom);
      s_old = m_src ^ m_pol;
      case (op)
        0: begin src = d; m_src = d; end
        1: begin wr(O_EN, {24'b0, d});    m_en = d; end
        2: begin wr(O_MODE, {24'b0, d});  m_mode = d; end
        3: begin wr(O_POL, {24'b0, d});   m_pol = d; end
        4: begin wr(O_PEND, {24'b0, d});  m_pend = m_pend & ~d; end
        default: begin wr(O_SWSET, {24'b0, d}); m_pend = m_pend | d; end
      endcase
      s_new = m_src ^ m_pol;
      // Any asserting transition pends; an asserted level-mode source stays pending.
      m_pend = m_pend | (s_new & ~s_old) | (s_new & ~m_mode);
      repeat (6) @(negedge clk);
      rd_chk($sformatf("rnd%0d_pending", step), O_PEND, {24'b0, m_pend});
      rd_chk($sformatf("rnd%0d_raw", step), O_RAW, {24'b0, s_new});
      rd_chk($sformatf("rnd%0d_enable", step), O_EN, {24'b0, m_en});
      chk($sformatf("rnd%0d_irq", step), irq, {19'b0, m_pend & m_en, 5'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
